// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding and memory map constants.
// Consumed by the OAM DMA sequencer and the PPU bus plumbing around it.
package ppu_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    localparam int          OAM_BYTES    = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies LEN bytes from {src_hi, 8'h00} into OAM, one per tick.
// Optional OAM_DMA_SRC_REMAP_EN folds echo RAM (E0xx-FFxx) onto C0xx-DFxx.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int LEN         = OAM_BYTES,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        reg_write,
    input  logic [7:0]  reg_d_wr,
    output logic [7:0]  reg_d_rd,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_d_in,
    output logic        dma_active,
    output logic        busy,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write
);

    localparam logic [7:0] LEN_LAST = 8'(LEN - 1);
    localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);
    localparam dma_state_t LOAD_ST  = (START_DELAY == 0) ? DMA_XFER : DMA_START;

    dma_state_t state_q, state_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] delay_ctr_q, delay_ctr_d;
    logic [7:0] oam_addr_q, oam_addr_d;
    logic [7:0] oam_d_wr_q, oam_d_wr_d;
    logic       oam_write_q, oam_write_d;
    logic [7:0] src_hi_eff;

`ifdef OAM_DMA_SRC_REMAP_EN
    assign src_hi_eff = (src_hi_q >= 8'hE0) ? src_hi_q - 8'h20 : src_hi_q;
`else
    assign src_hi_eff = src_hi_q;
`endif

    always_comb begin
        state_d     = state_q;
        src_hi_d    = src_hi_q;
        idx_d       = idx_q;
        delay_ctr_d = delay_ctr_q;
        oam_addr_d  = oam_addr_q;
        oam_d_wr_d  = oam_d_wr_q;
        oam_write_d = 1'b0;
        unique case (state_q)
            DMA_IDLE: ;
            DMA_START: begin
                if (tick && !reg_write) begin
                    if (delay_ctr_q == DLY_LAST) begin
                        state_d = DMA_XFER;
                    end else begin
                        delay_ctr_d = delay_ctr_q + 8'd1;
                    end
                end
            end
            DMA_XFER: begin
                if (tick) begin
                    oam_write_d = 1'b1;
                    oam_addr_d  = idx_q;
                    oam_d_wr_d  = dma_d_in;
                    idx_d       = idx_q + 8'd1;
                    if (idx_q == LEN_LAST) begin
                        state_d = DMA_IDLE;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase
        // A register write (re)starts the copy; in XFER the tick's byte above lands first.
        if (reg_write) begin
            src_hi_d    = reg_d_wr;
            idx_d       = 8'd0;
            delay_ctr_d = 8'd0;
            state_d     = LOAD_ST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DMA_IDLE;
            src_hi_q    <= 8'd0;
            idx_q       <= 8'd0;
            delay_ctr_q <= 8'd0;
            oam_addr_q  <= 8'd0;
            oam_d_wr_q  <= 8'd0;
            oam_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_hi_q    <= src_hi_d;
            idx_q       <= idx_d;
            delay_ctr_q <= delay_ctr_d;
            oam_addr_q  <= oam_addr_d;
            oam_d_wr_q  <= oam_d_wr_d;
            oam_write_q <= oam_write_d;
        end
    end

    assign reg_d_rd     = src_hi_q;
    assign dma_active   = (state_q == DMA_XFER);
    assign busy         = (state_q != DMA_IDLE);
    assign dma_src_addr = dma_active ? {src_hi_eff, idx_q} : 16'h0000;
    assign oam_addr     = oam_addr_q;
    assign oam_d_wr     = oam_d_wr_q;
    assign oam_write    = oam_write_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a tick-counting transfer model.
// Build with +define+OAM_DMA_SRC_REMAP_EN to exercise the echo-RAM remap.
module tb_oam_dma_ctrl;

    localparam int LEN = 160;
    localparam int DLY = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        reg_write;
    logic [7:0]  reg_d_wr;
    logic [7:0]  reg_d_rd;
    logic [15:0] dma_src_addr;
    logic [7:0]  dma_d_in;
    logic        dma_active;
    logic        busy;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_d_wr;
    logic        oam_write;

    logic [7:0] mem [65536];
    logic [7:0] dut_oam [256];
    logic [7:0] ref_oam [256];

    int n_chk  = 0;
    int n_fail = 0;
    int strobes;

    // Reference model: ticks counted since the last register write
    bit         m_active;
    int         m_cnt;
    logic [7:0] m_src;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    assign dma_d_in = mem[dma_src_addr];

    oam_dma_ctrl #(.LEN(LEN), .START_DELAY(DLY)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .reg_write(reg_write),
        .reg_d_wr(reg_d_wr),
        .reg_d_rd(reg_d_rd),
        .dma_src_addr(dma_src_addr),
        .dma_d_in(dma_d_in),
        .dma_active(dma_active),
        .busy(busy),
        .oam_addr(oam_addr),
        .oam_d_wr(oam_d_wr),
        .oam_write(oam_write)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] eff(input logic [7:0] s);
`ifdef OAM_DMA_SRC_REMAP_EN
        return (s >= 8'hE0) ? s - 8'h20 : s;
`else
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_cnt    = 0;
        m_src    = 8'h00;
        m_last   = 8'h00;
    endtask

    task automatic step(input bit tk, input bit wr, input logic [7:0] d);
        bit          exp_w;
        int          j;
        logic [7:0]  ea;
        logic [7:0]  ed;
        logic [15:0] sa;
        @(negedge clk);
        tick      = tk;
        reg_write = wr;
        reg_d_wr  = d;
        #1;
        exp_w = 0;
        ea    = 8'h00;
        ed    = 8'h00;
        if (tk && m_active) begin
            if (m_cnt >= DLY) begin
                j  = m_cnt - DLY;
                sa = {eff(m_src), 8'(j)};
                chk("src_addr", dma_src_addr, sa);
                exp_w = 1;
                ea    = 8'(j);
                ed    = mem[sa];
                ref_oam[ea] = ed;
                if (j == LEN - 1) m_active = 0;
            end
            m_cnt++;
        end
        if (wr) begin
            m_src    = d;
            m_last   = d;
            m_cnt    = 0;
            m_active = 1;
        end
        @(posedge clk);
        #1;
        tick      = 1'b0;
        reg_write = 1'b0;
        chk("oam_write", {15'd0, oam_write}, {15'd0, exp_w});
        if (oam_write) begin
            strobes++;
            dut_oam[oam_addr] = oam_d_wr;
        end
        if (exp_w) begin
            chk("oam_addr", {8'd0, oam_addr}, {8'd0, ea});
            chk("oam_data", {8'd0, oam_d_wr}, {8'd0, ed});
        end
        chk("busy", {15'd0, busy}, {15'd0, m_active});
        chk("dma_active", {15'd0, dma_active},
            {15'd0, (m_active && m_cnt >= DLY)});
        chk("reg_d_rd", {8'd0, reg_d_rd}, {8'd0, m_last});
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 8'h00);
            for (int g = 1; g < gap; g++) step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic cmp_oam(input string tag);
        for (int i = 0; i < LEN; i++) chk(tag, {8'd0, dut_oam[i]}, {8'd0, ref_oam[i]});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr"},   {15'd0, oam_write}, 16'd0);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_act"},  {15'd0, dma_active}, 16'd0);
        chk({tag, "_rd"},   {8'd0, reg_d_rd}, 16'd0);
        chk({tag, "_oa"},   {8'd0, oam_addr}, 16'd0);
        chk({tag, "_od"},   {8'd0, oam_d_wr}, 16'd0);
        chk({tag, "_sa"},   dma_src_addr, 16'h0000);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) begin
            dut_oam[a] = 8'h00;
            ref_oam[a] = 8'h00;
        end
        model_reset();
        rst       = 1'b1;
        tick      = 1'b0;
        reg_write = 1'b0;
        reg_d_wr  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full transfer from C100
        strobes = 0;
        step(1'b0, 1'b1, 8'hC1);
        run_ticks(LEN + DLY, 1);
        step(1'b0, 1'b0, 8'h00);
        chk("full_strobes", 16'(strobes), 16'd160);
        chk("full_rd", {8'd0, reg_d_rd}, 16'h00C1);
        cmp_oam("full_oam");

        // Restart after 50 bytes
        strobes = 0;
        step(1'b0, 1'b1, 8'hC0);
        run_ticks(DLY + 50, 1);
        step(1'b0, 1'b1, 8'hD0);
        run_ticks(DLY + LEN, 1);
        run_ticks(3, 1);
        chk("restart_strobes", 16'(strobes), 16'd210);
        cmp_oam("restart_oam");

        // Write coincident with the tick at idx 10
        step(1'b0, 1'b1, 8'hC3);
        run_ticks(DLY + 10, 1);
        step(1'b1, 1'b1, 8'hC8);
        chk("coinc_busy", {15'd0, busy}, 16'd1);
        run_ticks(DLY + LEN, 2);
        cmp_oam("coinc_oam");

        // Asynchronous reset at idx 80
        step(1'b0, 1'b1, 8'hC4);
        run_ticks(DLY + 80, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        run_ticks(10, 1);
        chk("midrst_strobes", 16'(strobes), 16'd0);

        // Echo source: remap depends on build
        step(1'b0, 1'b1, 8'hE5);
        run_ticks(DLY, 1);
        @(negedge clk);
        #1;
`ifdef OAM_DMA_SRC_REMAP_EN
        chk("echo_addr", dma_src_addr, 16'hC500);
`else
        chk("echo_addr", dma_src_addr, 16'hE500);
`endif
        chk("echo_rd", {8'd0, reg_d_rd}, 16'h00E5);
        run_ticks(LEN, 1);
        cmp_oam("echo_oam");

        // Sparse ticks: every 4 clks, then every 7 clks
        strobes = 0;
        step(1'b0, 1'b1, 8'h80);
        run_ticks(DLY + LEN, 4);
        cmp_oam("gap4_oam");
        step(1'b0, 1'b1, 8'hFE);
        run_ticks(DLY + LEN, 7);
        cmp_oam("gap7_oam");
        chk("gap_strobes", 16'(strobes), 16'd320);

        // Random ticks with occasional restarts
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0,
                 8'($urandom));
        end
        run_ticks(DLY + LEN + 2, 1);
        chk("rand_idle", {15'd0, busy}, 16'd0);
        cmp_oam("rand_oam");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the OAM DMA transfer: a write to the DMA register (FF46) copies LEN bytes from {src_hi, 8'h00} into OAM, one byte per M-cycle.
- Owns the dma_src_addr / dma_d_in / dma_active path into ppu_m and drives the OAM write port during the copy.
- Sits between the CPU bus decoder, the system bus mux (dma_active hands the bus to DMA) and ppu_m.

Parameters:
- LEN, 160, bytes per transfer; OAM size in bytes, at most 256.
- START_DELAY, 1, M-cycle ticks between the register write and the first bus read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  M-cycle enable: one-clk pulse, one per M-cycle
- reg_write  in  1  CPU write strobe to FF46
- reg_d_wr  in  8  CPU write data (source high byte)
- reg_d_rd  out  8  FF46 readback: last value written
- dma_src_addr  out  16  bus read address
- dma_d_in  in  8  bus read data; valid for the current dma_src_addr when tick is high
- dma_active  out  1  DMA owns the bus; CPU bus accesses are blocked
- busy  out  1  transfer pending or in progress (START or XFER)
- oam_addr  out  8  OAM byte index being written
- oam_d_wr  out  8  OAM write data
- oam_write  out  1  one-clk OAM write strobe

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, src_hi=0, idx=0, delay_ctr=0.
  - reg_d_rd=0, dma_active=0, busy=0, oam_write=0, oam_addr=0, oam_d_wr=0, dma_src_addr=16'h0000.
- States: IDLE, START, XFER.
- IDLE:
  - reg_write: src_hi<=reg_d_wr, delay_ctr<=0, idx<=0, go to START.
- START:
  - delay_ctr increments on each tick.
  - When a tick arrives with delay_ctr==START_DELAY-1, go to XFER.
  - START_DELAY=0: go straight from IDLE to XFER on the write.
- XFER:
  - dma_active=1.
  - dma_src_addr={src_hi_eff, idx} combinationally.
  - On each tick:
    - oam_write=1 for that clk only.
    - oam_addr=idx; oam_d_wr=dma_d_in, registered, so the strobe appears on the clk after the tick.
    - idx<=idx+1.
  - After the tick with idx==LEN-1, go to IDLE. dma_active drops on the next clk.
  - The last OAM write strobe still issues, one clk after the final tick.
- busy = (state != IDLE).
- Latency from reg_write (followed by its first tick) to the first oam_write strobe: START_DELAY+1 ticks plus 1 clk. A full transfer occupies LEN+START_DELAY M-cycles.
- reg_d_rd always returns the last written src_hi, including during a transfer.
- Restart: reg_write while in START or XFER reloads src_hi, idx=0, delay_ctr=0 and goes to START. dma_active drops while in START.
- Simultaneous reg_write and tick in XFER: the tick's byte is written first (old src, old idx), then the restart takes effect.
- tick is ignored in IDLE. reg_write while tick is low is still accepted.
- idx is 8 bits with no wrap past LEN-1. Arithmetic is unsigned.
- rst asserted mid-transfer:
  - Aborts immediately; no further oam_write.
  - OAM contents already written are left as-is.

Optional Feature:
- Macro: OAM_DMA_SRC_REMAP_EN.
- Defined: src_hi_eff = (src_hi >= 8'hE0) ? src_hi - 8'h20 : src_hi, so echo RAM E000–FFFF reads from C000–DFFF.
- Undefined: src_hi_eff = src_hi; the address is driven verbatim.
- reg_d_rd is unaffected in both cases.

Decomposition:
- Shared package (ppu_pkg):
  - dma_state_t enum {DMA_IDLE, DMA_START, DMA_XFER}.
  - OAM_BYTES=160.
  - DMA_REG_ADDR=16'hFF46.
- Single module; no sub-module is warranted.
- The bus-ownership mux stays in the top level and is driven by dma_active.

Test Plan:
- Reset, then write 8'hC1, then 161 ticks:
  - dma_src_addr steps C100..C19F.
  - 160 oam_write strobes with oam_addr 0..159 and data equal to the model memory.
  - busy falls after the last byte; reg_d_rd=8'hC1.
- Write 8'hC0, then restart with 8'hD0 after 50 bytes:
  - Bytes 0..49 come from C000..C031.
  - The next writes restart at oam_addr 0 from D000 after one START tick.
  - Total strobes = 50+160.
- reg_write coincident with the tick at idx=10:
  - Byte 10 is written from the old source.
  - State then goes to START with idx=0.
- rst pulsed at idx=80:
  - All outputs go to reset values on the same clk (async).
  - No further oam_write strobes.
  - dma_active=0.
- Write 8'hE5 with OAM_DMA_SRC_REMAP_EN defined: dma_src_addr starts at C500. With it undefined: starts at E500. In both builds reg_d_rd=8'hE5.
- Toggle tick gaps: tick every 4 clks vs every 7 clks. Exactly one strobe per tick; addresses and data stay correct.
